// File: rtl/audio_stream_ctrl.sv
`default_nettype none
// ============================================================================
// audio_stream_ctrl : assembles stereo frames from op words into a FIFO and
//                     paces them out to the DAC at 44.1 / 22.05 kHz.
// Rev 1.0
// ============================================================================
module audio_stream_ctrl #(
    parameter int FIFO_AW   = 4,
    parameter int DIV44     = 567,
    parameter int LOW_WATER = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] op,
    input  logic        op_valid,
    input  logic        is_audio_sample,
    input  logic        audio_starts,
    input  logic        all_1_packet,
    input  logic        power_on_packet_R1,
    output logic [15:0] sample_l,
    output logic [15:0] sample_r,
    output logic        sample_strobe,
    output logic        audio_req,
    output logic        streaming,
    output logic        rate_22k,
    output logic        underrun,
    output logic        overflow,
    output logic        powered_on
);

    localparam int              DEPTH      = 1 << FIFO_AW;
    localparam int              DW         = $clog2(2 * DIV44 + 1);
    localparam logic [DW-1:0]   DIV44_LAST = DW'(DIV44 - 1);
    localparam logic [DW-1:0]   DIV22_LAST = DW'(2 * DIV44 - 1);
    localparam logic [31:0]     LW_U       = 32'(LOW_WATER);
    localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_L    = 2'd1,
        IN_R    = 2'd2
    } in_state_t;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_PRIME = 2'd1,
        P_PLAY  = 2'd2
    } play_state_t;

    in_state_t          in_state_q;
    play_state_t        play_state_q;
    logic [15:0]        left_q;
    logic [31:0]        fifo_mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic [DW-1:0]      div_q;
    logic [15:0]        sample_l_q;
    logic [15:0]        sample_r_q;
    logic               strobe_q;
    logic               rate_q;
    logic               underrun_q;
    logic               overflow_q;
    logic               powered_q;

    logic               w_idle_op;
    logic               w_reset_all;
    logic               w_start;
    logic               w_header;
    logic               w_power;
    logic               w_push;
    logic               w_full;
    logic               w_tick;
    logic               w_pop;
    logic               w_push_ok;
    logic [DW-1:0]      w_div_last;

    // Decoder flags only mean something between frames; inside a frame every word is data.
    assign w_idle_op   = op_valid && (in_state_q == IN_IDLE);
    assign w_reset_all = w_idle_op && all_1_packet;
    assign w_start     = w_idle_op && audio_starts && !all_1_packet;
    assign w_power     = w_idle_op && power_on_packet_R1;
    assign w_header    = w_idle_op && is_audio_sample && !all_1_packet && !audio_starts
                         && streaming;
    assign w_push      = op_valid && (in_state_q == IN_R);
    assign w_full      = (count_q == FULL_CNT);
    assign w_div_last  = rate_q ? DIV22_LAST : DIV44_LAST;
    assign w_tick      = (play_state_q == P_PLAY) && (div_q == w_div_last);
    assign w_pop       = w_tick && (count_q != '0);
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign count_d     = count_q + {{FIFO_AW{1'b0}}, w_push_ok} - {{FIFO_AW{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            fifo_mem_q[wr_ptr_q] <= {left_q, op};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q   <= IN_IDLE;
            play_state_q <= P_IDLE;
            left_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            div_q        <= '0;
            sample_l_q   <= '0;
            sample_r_q   <= '0;
            strobe_q     <= 1'b0;
            rate_q       <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
            powered_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (w_power) begin
                powered_q <= 1'b1;
            end

            if (w_reset_all) begin
                in_state_q   <= IN_IDLE;
                play_state_q <= P_IDLE;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                count_q      <= '0;
                div_q        <= '0;
                sample_l_q   <= '0;
                sample_r_q   <= '0;
                rate_q       <= 1'b0;
                underrun_q   <= 1'b0;
                overflow_q   <= 1'b0;
                powered_q    <= 1'b0;
            end else if (w_start) begin
                in_state_q   <= IN_IDLE;
                play_state_q <= P_PRIME;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                count_q      <= '0;
                div_q        <= '0;
                rate_q       <= op[12];
                underrun_q   <= 1'b0;
                overflow_q   <= 1'b0;
            end else begin
                case (in_state_q)
                    IN_IDLE: if (w_header) in_state_q <= IN_L;
                    IN_L: begin
                        if (op_valid) begin
                            left_q     <= op;
                            in_state_q <= IN_R;
                        end
                    end
                    IN_R: if (op_valid) in_state_q <= IN_IDLE;
                    default: in_state_q <= IN_IDLE;
                endcase

                if (w_push && !w_push_ok) begin
                    overflow_q <= 1'b1;
                end
                if (w_push_ok) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                count_q <= count_d;

                case (play_state_q)
                    P_IDLE: ;
                    P_PRIME: begin
                        if (32'(count_q) >= LW_U) begin
                            play_state_q <= P_PLAY;
                            div_q        <= '0;
                        end
                    end
                    P_PLAY: begin
                        if (w_tick) begin
                            div_q    <= '0;
                            strobe_q <= 1'b1;
                            if (w_pop) begin
                                sample_l_q <= fifo_mem_q[rd_ptr_q][31:16];
                                sample_r_q <= fifo_mem_q[rd_ptr_q][15:0];
                                rd_ptr_q   <= rd_ptr_q + 1'b1;
                            end else begin
                                sample_l_q <= '0;
                                sample_r_q <= '0;
                                underrun_q <= 1'b1;
                            end
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end
                    default: play_state_q <= P_IDLE;
                endcase
            end
        end
    end

    assign sample_l      = sample_l_q;
    assign sample_r      = sample_r_q;
    assign sample_strobe = strobe_q;
    assign streaming     = (play_state_q != P_IDLE);
    assign audio_req     = streaming && (32'(count_q) < LW_U);
    assign rate_22k      = rate_q;
    assign underrun      = underrun_q;
    assign overflow      = overflow_q;
    assign powered_on    = powered_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_stream_ctrl.sv
`default_nettype none
// ============================================================================
// tb_audio_stream_ctrl : directed self-checking bench for audio_stream_ctrl.
// Rev 1.0
// ============================================================================
module tb_audio_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] op = '0;
    logic        op_valid = 1'b0;
    logic        is_audio_sample = 1'b0;
    logic        audio_starts = 1'b0;
    logic        all_1_packet = 1'b0;
    logic        power_on_packet_R1 = 1'b0;

    logic [15:0] sample_l, sample_r;
    logic        sample_strobe, audio_req, streaming, rate_22k, underrun, overflow, powered_on;

    logic [15:0] o_sample_l, o_sample_r;
    logic        o_sample_strobe, o_audio_req, o_streaming, o_rate_22k;
    logic        o_underrun, o_overflow, o_powered_on;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    audio_stream_ctrl u_dut (
        .clk(clk), .rst(rst), .op(op), .op_valid(op_valid),
        .is_audio_sample(is_audio_sample), .audio_starts(audio_starts),
        .all_1_packet(all_1_packet), .power_on_packet_R1(power_on_packet_R1),
        .sample_l(sample_l), .sample_r(sample_r), .sample_strobe(sample_strobe),
        .audio_req(audio_req), .streaming(streaming), .rate_22k(rate_22k),
        .underrun(underrun), .overflow(overflow), .powered_on(powered_on)
    );

    // Never leaves PRIME, so the FIFO can be filled past capacity.
    audio_stream_ctrl #(.LOW_WATER(32)) u_ovf (
        .clk(clk), .rst(rst), .op(op), .op_valid(op_valid),
        .is_audio_sample(is_audio_sample), .audio_starts(audio_starts),
        .all_1_packet(all_1_packet), .power_on_packet_R1(power_on_packet_R1),
        .sample_l(o_sample_l), .sample_r(o_sample_r), .sample_strobe(o_sample_strobe),
        .audio_req(o_audio_req), .streaming(o_streaming), .rate_22k(o_rate_22k),
        .underrun(o_underrun), .overflow(o_overflow), .powered_on(o_powered_on)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one word for one cycle with the flags the op decoder would raise.
    task automatic send(input logic [15:0] w);
        op                 = w;
        op_valid           = 1'b1;
        is_audio_sample    = (w[15:8] == 8'hC7);
        audio_starts       = (w[15:8] == 8'h1F) || (w[15:8] == 8'h0F);
        all_1_packet       = (w[15:8] == 8'hFF);
        power_on_packet_R1 = (w == 16'hC5EF);
        @(posedge clk); #1;
        op                 = '0;
        op_valid           = 1'b0;
        is_audio_sample    = 1'b0;
        audio_starts       = 1'b0;
        all_1_packet       = 1'b0;
        power_on_packet_R1 = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send(16'hC700);
        send(l);
        send(r);
    endtask

    task automatic wait_strobe(input int bound, output int cycles);
        cycles = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (sample_strobe === 1'b1) break;
        end
    endtask

    initial begin
        // ---- reset ----
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_outputs",
              {sample_l, sample_r},
              32'h0);
        check("rst_flags",
              {25'd0, sample_strobe, audio_req, streaming, rate_22k, underrun, overflow, powered_on},
              32'h0);

        // ---- 1: 44.1 kHz start, prime, first strobe ----
        send(16'h0F00);
        check("t1_streaming", {31'd0, streaming}, 32'd1);
        check("t1_rate", {31'd0, rate_22k}, 32'd0);
        send_frame(16'h1111, 16'h2222);
        send_frame(16'h3333, 16'h4444);
        send_frame(16'h5555, 16'h6666);
        send_frame(16'h7777, 16'h8888);
        check("t1_req_at_low_water", {31'd0, audio_req}, 32'd0);
        wait_strobe(3000, n);
        check("t1_first_strobe_latency", n, 32'd568);
        check("t1_first_frame", {sample_l, sample_r}, 32'h1111_2222);
        check("t1_req_after_pop", {31'd0, audio_req}, 32'd1);
        wait_strobe(3000, n);
        check("t1_strobe_spacing", n, 32'd567);
        check("t1_second_frame", {sample_l, sample_r}, 32'h3333_4444);

        // ---- 2: 22.05 kHz restart ----
        send(16'h1F00);
        check("t2_rate", {31'd0, rate_22k}, 32'd1);
        send_frame(16'hA001, 16'hB001);
        send_frame(16'hA002, 16'hB002);
        send_frame(16'hA003, 16'hB003);
        send_frame(16'hA004, 16'hB004);
        wait_strobe(3000, n);
        check("t2_first_latency", n, 32'd1135);
        check("t2_frame1", {sample_l, sample_r}, 32'hA001_B001);
        wait_strobe(3000, n);
        check("t2_strobe_spacing", n, 32'd1134);
        check("t2_frame2", {sample_l, sample_r}, 32'hA002_B002);

        // ---- 3: drain to underrun ----
        wait_strobe(3000, n);
        check("t3_frame3", {sample_l, sample_r}, 32'hA003_B003);
        wait_strobe(3000, n);
        check("t3_frame4", {sample_l, sample_r}, 32'hA004_B004);
        check("t3_no_underrun_yet", {31'd0, underrun}, 32'd0);
        wait_strobe(3000, n);
        check("t3_underrun_spacing", n, 32'd1134);
        check("t3_underrun_samples", {sample_l, sample_r}, 32'h0);
        check("t3_underrun_flag", {31'd0, underrun}, 32'd1);
        check("t3_still_streaming", {31'd0, streaming}, 32'd1);
        send(16'h0F00);
        check("t3_underrun_cleared", {31'd0, underrun}, 32'd0);
        check("t3_rate_44k", {31'd0, rate_22k}, 32'd0);

        // ---- 4: overflow with no pops ----
        for (int i = 0; i < 16; i++) begin
            send_frame(16'h4000 + 16'(i), 16'h5000 + 16'(i));
        end
        check("t4_count_full", {27'd0, u_ovf.count_q}, 32'd16);
        check("t4_no_overflow_at_16", {31'd0, o_overflow}, 32'd0);
        send_frame(16'h4010, 16'h5010);
        check("t4_overflow", {31'd0, o_overflow}, 32'd1);
        check("t4_count_after_drop", {27'd0, u_ovf.count_q}, 32'd16);
        check("t4_ovf_req", {31'd0, o_audio_req}, 32'd1);
        check("t4_main_overflow", {31'd0, overflow}, 32'd1);

        // ---- 5: flag-like words inside a frame, then full stream reset ----
        send(16'h0F00);
        check("t5_overflow_cleared", {31'd0, overflow}, 32'd0);
        send(16'hC700);
        send(16'hFFFF);
        send(16'hFF00);
        check("t5_no_reset_in_frame", {31'd0, streaming}, 32'd1);
        send_frame(16'h0A0A, 16'h0B0B);
        send_frame(16'h0C0C, 16'h0D0D);
        send_frame(16'h0E0E, 16'h0101);
        wait_strobe(3000, n);
        check("t5_data_frame", {sample_l, sample_r}, 32'hFFFF_FF00);
        send(16'hC5EF);
        check("t5_powered", {31'd0, powered_on}, 32'd1);
        send(16'hFF00);
        check("t5_streaming_off", {30'd0, streaming, audio_req}, 32'd0);
        check("t5_samples_zero", {sample_l, sample_r}, 32'h0);
        check("t5_powered_cleared", {31'd0, powered_on}, 32'd0);
        check("t5_fifo_empty", {27'd0, u_dut.count_q}, 32'd0);

        // ---- 6: power-on flag, reset mid-frame ----
        send(16'hC5EF);
        send(16'h1F00);
        check("t6_powered_kept", {30'd0, powered_on, rate_22k}, 32'd3);
        send(16'hC700);
        send(16'h1234);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_flags",
              {25'd0, sample_strobe, audio_req, streaming, rate_22k, underrun, overflow, powered_on},
              32'h0);
        check("t6_rst_samples", {sample_l, sample_r}, 32'h0);
        rst = 1'b0;
        send(16'h0F00);
        check("t6_partial_discarded", {30'd0, streaming, rate_22k}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
